// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: constants and state encodings shared by the 8N1 UART blocks.
//   CLKS_PER_BIT_DEF : default clk cycles per bit (100 MHz / 9600 baud)
//   DATA_BITS        : data bits per frame
//   SYNC_STAGES_DEF  : default depth of the RX input synchronizer
//   rx_state_t       : receiver FSM states
package uart_defs_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 10417;
   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned SYNC_STAGES_DEF  = 2;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for the asynchronous RX pin.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset; chain resets to 1 (idle line)
//   Rxd : raw serial input
//   rxs : synchronized serial input, SYNC_STAGES cycles behind Rxd
module uart_rx_sync
   import uart_defs_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic Rxd,
   output logic rxs
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '1;
      end else begin
         sr <= {sr[SYNC_STAGES-2:0], Rxd};
      end
   end

   assign rxs = sr[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver (start, 8 data bits LSB first, stop).
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   Rxd       : serial line, idle high, asynchronous to clk
//   rx_data   : last correctly received byte, held until the next good byte
//   rx_valid  : one-cycle pulse, rx_data is new in the same cycle
//   frame_err : one-cycle pulse when the stop bit samples 0
//   busy      : high whenever the receiver is not idle
module uart_byte_rx
   import uart_defs_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic             rxs;

   rx_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic [7:0]       rx_data_n;
   logic             rx_valid_n, frame_err_n;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .Rxd (Rxd),
      .rxs (rxs)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         frame_err <= frame_err_n;
      end
   end

   // The bit timer is cleared at every sample and held at zero in the
   // waiting states, so it never needs to count past BIT_LIM.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt + 1'b1;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      rx_data_n   = rx_data;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         RX_IDLE: begin
            cnt_n = '0;
            if (!rxs) begin
               state_n = RX_START;
            end
         end

         // Mid start bit: a line back high means the falling edge was a glitch.
         RX_START: begin
            if (cnt == HALF_LIM) begin
               cnt_n = '0;
               if (!rxs) begin
                  state_n   = RX_DATA;
                  bit_idx_n = '0;
               end else begin
                  state_n = RX_IDLE;
               end
            end
         end

         RX_DATA: begin
            if (cnt == BIT_LIM) begin
               cnt_n     = '0;
               shreg_n   = {rxs, shreg[7:1]};
               bit_idx_n = bit_idx + 1'b1;
               if (bit_idx == LAST_BIT) begin
                  state_n = RX_STOP;
               end
            end
         end

         // Leaving mid stop bit lets a start bit that immediately follows
         // a one-bit stop be caught without any idle gap.
         RX_STOP: begin
            if (cnt == BIT_LIM) begin
               cnt_n = '0;
               if (rxs) begin
                  rx_data_n  = shreg;
                  rx_valid_n = 1'b1;
                  state_n    = RX_IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = RX_WAIT_HIGH;
               end
            end
         end

         // A held-low line (break) must not be read as a stream of 0x00 bytes.
         RX_WAIT_HIGH: begin
            cnt_n = '0;
            if (rxs) begin
               state_n = RX_IDLE;
            end
         end

         default: begin
            cnt_n   = '0;
            state_n = RX_IDLE;
         end
      endcase
   end

   assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx at 16 clk per bit.
module tb_uart_byte_rx;

   localparam int unsigned BIT = 16;
   localparam int unsigned LAT = 2 + BIT / 2 + 9 * BIT + 1;

   typedef struct {
      logic        err;
      logic [7:0]  data;
      int unsigned t0;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   exp_t        sb[$];
   int unsigned cyc;
   int unsigned vec_cnt;
   int unsigned err_cnt;
   logic [7:0]  last_good;

   uart_byte_rx #(
      .CLKS_PER_BIT (BIT),
      .SYNC_STAGES  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .Rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drives one bit for exactly BIT cycles; entered and left 1 time unit after a rising edge.
   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      sb.push_back('{err: !stop, data: d, t0: cyc});
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic idle_bits(input int unsigned n);
      rxd = 1'b1;
      repeat (n * BIT) @(posedge clk);
      #1;
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t        e;
      int unsigned lat;
      if (rst && (rx_valid || frame_err)) begin
         if (rx_valid && frame_err) check("valid_err_excl", 32'd1, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, frame_err, rx_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            lat = cyc - e.t0;
            check("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
            check("latency_window", {31'd0, (lat + 1 >= LAT) && (lat <= LAT + 1)}, 32'd1);
            if (rx_valid) begin
               check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
               check("busy_after_stop", {31'd0, busy}, 32'd0);
               last_good = e.data;
            end else begin
               check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
            end
         end
      end
   end

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      last_good = 8'h00;
      rst       = 1'b0;
      rxd       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      idle_bits(2);

      // Good byte
      send_frame(8'hA5, 1'b1);
      idle_bits(2);

      // Glitch shorter than half a bit
      rxd = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (BIT) @(posedge clk);
      #1;
      check("glitch_busy", {31'd0, busy}, 32'd0);
      check("glitch_no_event", sb.size(), 32'd0);
      idle_bits(1);

      // Framing error, rx_data must keep 8'hA5
      send_frame(8'h3C, 1'b0);
      idle_bits(3);

      // Break: 30 bit times low, then a good byte
      sb.push_back('{err: 1'b1, data: 8'h00, t0: cyc});
      rxd = 1'b0;
      repeat (30 * BIT) @(posedge clk);
      #1;
      check("break_busy", {31'd0, busy}, 32'd1);
      idle_bits(2);
      send_frame(8'h5A, 1'b1);
      idle_bits(2);

      // Reset in the middle of an 8'hFF frame after 4 data bits
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rst = 1'b0;
      #1;
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      last_good = 8'h00;
      rxd = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      idle_bits(2);
      send_frame(8'h81, 1'b1);
      idle_bits(2);

      // Back-to-back frames, one stop bit, no idle gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      idle_bits(2);

      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 32'd0);
      check("final_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $fatal(1);
   end

endmodule
